// File: rtl/trig_pkg.sv
// Shared types and default sizing for the trigger unit.
package trig_pkg;

  typedef enum logic [1:0] {
    TRIG_FALL = 2'b00,
    TRIG_RISE = 2'b01,
    TRIG_BOTH = 2'b10,
    TRIG_OFF  = 2'b11
  } trig_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRIG    = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLDOFF_W   = 16;

endpackage

// File: rtl/trig_sync_edge.sv
// One trigger channel: metastability synchroniser, previous-level flop and
// registered rise/fall strobes.
module trig_sync_edge
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;
  logic                   rise_p2;
  logic                   fall_p2;

  // Stage 0: synchroniser chain, oldest sample in the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
    end
  end

  // Stage 1/2: previous level and registered edge strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p1 <= 1'b0;
      rise_p2 <= 1'b0;
      fall_p2 <= 1'b0;
    end else begin
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      rise_p2 <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
      fall_p2 <= ~sync_p0[SYNC_STAGES-1] & prev_p1;
    end
  end

  assign rise = rise_p2;
  assign fall = fall_p2;

endmodule

// File: rtl/trig_unit.sv
// Multi-channel trigger unit: per-channel edge detect, source/mode select,
// latched trigger with holdoff. Auto-trigger timeout enabled by TRIG_AUTO_EN.
module trig_unit
  import trig_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLDOFF_W   = DEF_HOLDOFF_W,
  parameter int AUTO_CYCLES = 65536,
  localparam int SRC_W      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    trig_in,
  input  logic [SRC_W-1:0]     trigSrc,
  input  logic [1:0]           trigMode,
  input  logic                 armed,
  input  logic                 trig_en,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 set_capture_done,
  output logic                 triggered,
  output logic                 trig_pulse,
  output logic                 holdoff_busy,
  output logic                 auto_trig
);

  logic [NUM_CH-1:0]    rise_v;
  logic [NUM_CH-1:0]    fall_v;
  logic [NUM_CH-1:0]    edge_v;
  logic                 evt;
  logic                 auto_hit;
  logic                 go;
  trig_state_e          state, state_nxt;
  logic [HOLDOFF_W-1:0] cnt, cnt_nxt;
  logic                 pulse_q, pulse_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    trig_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (trig_in[g]),
      .rise (rise_v[g]),
      .fall (fall_v[g])
    );
  end

  // Edge choice is made on every channel before the source mux, so moving
  // trigSrc between channels at different levels never looks like an edge.
  always_comb begin
    edge_v = '0;
    case (trig_mode_e'(trigMode))
      TRIG_FALL: edge_v = fall_v;
      TRIG_RISE: edge_v = rise_v;
      TRIG_BOTH: edge_v = rise_v | fall_v;
      default:   edge_v = '0;
    endcase
  end

  always_comb begin
    evt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (trigSrc == SRC_W'(i)) evt = edge_v[i];
    end
  end

  assign go = armed & trig_en & ~set_capture_done & (evt | auto_hit);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = TRIG;
          pulse_nxt = 1'b1;
        end
      end
      TRIG: begin
        if (set_capture_done) begin
          if (holdoff == '0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = holdoff;
            state_nxt = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= HOLDOFF_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 3: FSM state, holdoff count and trigger pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  assign triggered    = (state == TRIG);
  assign holdoff_busy = (state == HOLDOFF);
  assign trig_pulse   = pulse_q;

`ifdef TRIG_AUTO_EN
  localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_q;

  assign auto_hit = (auto_cnt == AUTO_W'(AUTO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if ((state != IDLE) || !(armed & trig_en)) begin
      auto_cnt <= '0;
    end else if (!auto_hit) begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  // A real edge in the timeout cycle wins, so the flag only marks pure timeouts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q <= 1'b0;
    end else if (state == IDLE) begin
      auto_q <= go & ~evt;
    end else begin
      auto_q <= auto_q & (state_nxt == TRIG);
    end
  end

  assign auto_trig = auto_q;
`else
  // Timeout compiled out; this comparison is false for every legal AUTO_CYCLES.
  assign auto_hit  = (AUTO_CYCLES == 0);
  assign auto_trig = 1'b0;
`endif

endmodule

// File: tb/tb_trig_unit.sv
// Directed bench for trig_unit: vector table for edge/mode/source qualification
// plus hand sequences for holdoff, reset, source switching and auto-trigger.
module tb_trig_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  trig_in;
  logic [1:0]  trigSrc;
  logic [1:0]  trigMode;
  logic        armed;
  logic        trig_en;
  logic [15:0] holdoff;
  logic        set_capture_done;
  logic        triggered;
  logic        trig_pulse;
  logic        holdoff_busy;
  logic        auto_trig;

  int n_vec = 0;
  int n_err = 0;

  trig_unit #(
    .NUM_CH     (4),
    .SYNC_STAGES(2),
    .HOLDOFF_W  (16),
    .AUTO_CYCLES(16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trig_in         (trig_in),
    .trigSrc         (trigSrc),
    .trigMode        (trigMode),
    .armed           (armed),
    .trig_en         (trig_en),
    .holdoff         (holdoff),
    .set_capture_done(set_capture_done),
    .triggered       (triggered),
    .trig_pulse      (trig_pulse),
    .holdoff_busy    (holdoff_busy),
    .auto_trig       (auto_trig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] src;
    logic       arm;
    logic       en;
    logic [3:0] tin0;
    logic [3:0] tin1;
    logic       exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_trig();
    holdoff = 16'd0;
    set_capture_done = 1'b1;
    cyc(1);
    set_capture_done = 1'b0;
  endtask

  // Settle channel 2 low while disarmed, then raise it armed in rising mode.
  task automatic fire_ch2();
    armed = 1'b0; trig_en = 1'b0;
    trigMode = 2'b01; trigSrc = 2'd2;
    trig_in = 4'b0000;
    cyc(5);
    armed = 1'b1; trig_en = 1'b1;
    trig_in = 4'b0100;
    cyc(4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n;

    tbl[0]  = '{2'b01, 2'd2, 1'b1, 1'b1, 4'b0000, 4'b0100, 1'b1};
    tbl[1]  = '{2'b01, 2'd2, 1'b1, 1'b1, 4'b0000, 4'b1011, 1'b0};
    tbl[2]  = '{2'b10, 2'd1, 1'b1, 1'b1, 4'b1111, 4'b1101, 1'b1};
    tbl[3]  = '{2'b11, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0};
    tbl[4]  = '{2'b11, 2'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0};
    tbl[5]  = '{2'b01, 2'd3, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0};
    tbl[6]  = '{2'b00, 2'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b1};
    tbl[7]  = '{2'b00, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0};
    tbl[8]  = '{2'b10, 2'd3, 1'b1, 1'b1, 4'b0000, 4'b1000, 1'b1};
    tbl[9]  = '{2'b01, 2'd1, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0};
    tbl[10] = '{2'b01, 2'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0};
    tbl[11] = '{2'b00, 2'd2, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1};

    rst_n = 1'b0;
    trig_in = 4'b0000; trigSrc = 2'd0; trigMode = 2'b01;
    armed = 1'b0; trig_en = 1'b0; holdoff = 16'd0; set_capture_done = 1'b0;
    cyc(2);
    chk("reset triggered", triggered, 1'b0);
    chk("reset trig_pulse", trig_pulse, 1'b0);
    chk("reset holdoff_busy", holdoff_busy, 1'b0);
    chk("reset auto_trig", auto_trig, 1'b0);
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 12; i++) begin
      armed = 1'b0; trig_en = 1'b0; set_capture_done = 1'b0;
      trig_in = tbl[i].tin0;
      cyc(5);
      trigMode = tbl[i].mode; trigSrc = tbl[i].src;
      armed = tbl[i].arm; trig_en = tbl[i].en;
      trig_in = tbl[i].tin1;
      cyc(3);
      chk($sformatf("v%0d early triggered", i), triggered, 1'b0);
      cyc(1);
      chk($sformatf("v%0d triggered", i), triggered, tbl[i].exp);
      chk($sformatf("v%0d trig_pulse", i), trig_pulse, tbl[i].exp);
      chk($sformatf("v%0d auto_trig", i), auto_trig, 1'b0);
      cyc(1);
      chk($sformatf("v%0d pulse one cycle", i), trig_pulse, 1'b0);
      chk($sformatf("v%0d triggered held", i), triggered, tbl[i].exp);
      armed = 1'b0; trig_en = 1'b0;
      clear_trig();
      chk($sformatf("v%0d cleared", i), triggered, 1'b0);
    end

    // Latched trigger, holdoff length, edge ignored in holdoff, edge after it.
    fire_ch2();
    chk("hold fire", triggered, 1'b1);
    trig_en = 1'b0;
    trig_in = 4'b0000;
    cyc(4);
    chk("hold latched", triggered, 1'b1);
    holdoff = 16'd5;
    set_capture_done = 1'b1;
    cyc(1);
    set_capture_done = 1'b0;
    holdoff = 16'd9;
    chk("hold triggered falls", triggered, 1'b0);
    trig_en = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) trig_in = 4'b0100;
      if (holdoff_busy) busy_n++;
      cyc(1);
    end
    chk_n("hold busy cycles", busy_n, 5);
    chk("hold edge ignored", triggered, 1'b0);
    trig_in = 4'b0000;
    cyc(4);
    trig_in = 4'b0100;
    cyc(4);
    chk("post-hold edge", triggered, 1'b1);
    clear_trig();
    chk("zero holdoff to idle", triggered, 1'b0);
    chk("zero holdoff no busy", holdoff_busy, 1'b0);

    // Asynchronous reset while triggered (trig_pulse still high).
    fire_ch2();
    chk("rst trig pre", trig_pulse, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst trig triggered", triggered, 1'b0);
    chk("rst trig pulse", trig_pulse, 1'b0);
    trig_in = 4'b0000;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    trig_in = 4'b0100;
    cyc(4);
    chk("rst trig refire", triggered, 1'b1);

    // Asynchronous reset during holdoff.
    holdoff = 16'd5;
    set_capture_done = 1'b1;
    cyc(1);
    set_capture_done = 1'b0;
    chk("rst hold pre", holdoff_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst hold busy", holdoff_busy, 1'b0);
    chk("rst hold triggered", triggered, 1'b0);
    trig_in = 4'b0000;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    trig_in = 4'b0100;
    cyc(4);
    chk("rst hold refire", triggered, 1'b1);
    armed = 1'b0; trig_en = 1'b0;
    clear_trig();

    // Source switch between channels at different static levels.
    trig_in = 4'b0010; trigMode = 2'b01; trigSrc = 2'd0;
    cyc(5);
    armed = 1'b1; trig_en = 1'b1;
    trigSrc = 2'd1;
    cyc(5);
    chk("src switch no trigger", triggered, 1'b0);

    // Capture-done coinciding with the event cycle in IDLE.
    armed = 1'b0; trig_en = 1'b0;
    trig_in = 4'b0000; trigSrc = 2'd0;
    cyc(5);
    armed = 1'b1; trig_en = 1'b1;
    trig_in = 4'b0001;
    cyc(3);
    set_capture_done = 1'b1;
    cyc(1);
    set_capture_done = 1'b0;
    cyc(2);
    chk("done beats evt", triggered, 1'b0);
    armed = 1'b0; trig_en = 1'b0;
    cyc(1);

`ifdef TRIG_AUTO_EN
    // Pure timeout: 16 armed IDLE cycles.
    trig_in = 4'b0000; trigSrc = 2'd0; trigMode = 2'b01;
    cyc(5);
    armed = 1'b1; trig_en = 1'b1;
    cyc(15);
    chk("auto early", triggered, 1'b0);
    cyc(1);
    chk("auto triggered", triggered, 1'b1);
    chk("auto flag", auto_trig, 1'b1);
    chk("auto pulse", trig_pulse, 1'b1);
    armed = 1'b0; trig_en = 1'b0;
    clear_trig();
    chk("auto flag clears", auto_trig, 1'b0);
    cyc(2);
    // Real edge landing in the timeout cycle wins.
    armed = 1'b1; trig_en = 1'b1;
    cyc(12);
    trig_in = 4'b0001;
    cyc(4);
    chk("auto real edge trig", triggered, 1'b1);
    chk("auto real edge flag", auto_trig, 1'b0);
    armed = 1'b0; trig_en = 1'b0;
    clear_trig();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
